// File: rtl/mux4_scan_ctrl.sv
// Select-line sequencer for a 4x1 mux: scans the enabled channels in ascending
// order, holds each select for DWELL cycles, and captures the mux output per channel.
module mux4_scan_ctrl #(
  parameter int unsigned DWELL = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] mask,
  input  logic       mux_o,
  output logic       s1,
  output logic       s0,
  output logic [3:0] sample,
  output logic       busy,
  output logic       valid
);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  localparam logic [3:0] RELOAD = 4'(DWELL - 1);

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] mask_q, mask_d;
  logic [3:0] sample_q, sample_d;
  logic       valid_q, valid_d;

  logic [1:0] first_ch;
  logic [1:0] next_ch;
  logic       next_found;

  // Walk from high to low so the lowest qualifying channel is the one left standing.
  always_comb begin
    first_ch   = '0;
    next_ch    = '0;
    next_found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (mask[3 - i]) first_ch = 2'(3 - i);
      if (mask_q[3 - i] && (2'(3 - i) > sel_q)) begin
        next_ch    = 2'(3 - i);
        next_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sample_d = '0;
          if (mask != 4'b0000) begin
            mask_d  = mask;
            sel_d   = first_ch;
            cnt_d   = RELOAD;
            state_d = SCAN;
          end else begin
            valid_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          sample_d[sel_q] = mux_o;
          if (next_found) begin
            sel_d = next_ch;
            cnt_d = RELOAD;
          end else begin
            sel_d   = '0;
            valid_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  assign s1     = sel_q[1];
  assign s0     = sel_q[0];
  assign sample = sample_q;
  assign busy   = (state_q == SCAN);
  assign valid  = valid_q;

endmodule
